int_mul_iter: RTL
=================

# int_mul_iter

Iterative digit-serial integer multiplier that produces the 2·LOGQ-bit product C = A·B consumed by the word-level Montgomery reduction stage. It sits directly upstream of that reducer and forwards the modulus high word qH aligned with each product. One W-bit digit of B is processed per cycle, so a single DSP-sized multiply-accumulate column is reused D = ceil(LOGQ/W) times. A ready/valid input and a single-cycle output valid pulse match the downstream reducer, which has fixed latency and cannot stall.

## Interface
- LOGQ, 60, operand width in bits.
- R, 17, reduction word width of the downstream stage; sets the qH width.
- W, 17, digit width of B processed per cycle (DSP input width).
- Derived, not overridable: K = 2·LOGQ, LOGQH = LOGQ − R, D = ceil(LOGQ/W).
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  A, B and qH_in are valid.
- in_ready  out  1  the block can accept a new operand pair.
- A  in  LOGQ  multiplicand.
- B  in  LOGQ  multiplier, consumed one digit per cycle.
- qH_in  in  LOGQH  modulus high word, captured together with A and B.
- out_valid  out  1  single-cycle pulse; C and qH_out are valid.
- C  out  K  product A·B.
- qH_out  out  LOGQH  qH captured with the operands that produced C.

## Operation
- FSM states: IDLE, MUL, OUT.
- in_ready = (state is IDLE or OUT) and rst is high. It is combinational from state and is forced to 0 while reset is asserted.
- Accept: when in_valid and in_ready are both high on a rising edge, the block:
  - registers A, B and qH_in;
  - clears the accumulator;
  - clears the digit counter j;
  - moves to MUL.
- MUL: on each edge, acc ← acc + ((A · b_j) << j·W), where b_j = B[j·W +: W].
  - The top digit is B[LOGQ−1:(D−1)·W], zero-extended to W bits.
  - j increments by 1 per edge.
  - On the edge where j = D−1 is added, the state goes to OUT.
- OUT: out_valid = 1 for exactly this cycle, with C = acc and qH_out = the captured qH.
  - If an accept happens in this cycle, the next state is MUL; otherwise it is IDLE.
- C and qH_out hold their values after the pulse until the next OUT cycle. Consumers sample them only when out_valid is high.
- Width rule: A, B < 2^LOGQ, so A·B < 2^K. The accumulator is K bits and never overflows. Each partial product is LOGQ+W bits, added into acc[j·W +: LOGQ+W] with carry into the upper bits.
- in_valid while in_ready is low: ignored; no input is captured. The source must hold its data until in_ready is high.
- Reset (asynchronous, any state, including mid-MUL): state ← IDLE, j ← 0, acc ← 0.
  - Outputs: out_valid = 0, C = 0, qH_out = 0, in_ready = 0 while rst is low.
  - An operation in flight is discarded and never produces out_valid.
  - After rst deasserts, in_ready = 1.

## Timing
- An accept edge starts cycle 0. MUL occupies cycles 1..D, and out_valid is high in cycle D+1. For the defaults (D = 4), out_valid rises 5 cycles after the accept edge.
- Throughput: back-to-back accepts in the OUT cycle give one result every D+1 cycles (every 5 cycles with the defaults).
- No combinational path from in_valid to out_valid or C. in_ready depends only on state and rst.
- The critical path is one LOGQ×W multiply plus a K-bit add. The multiply maps to DSP slices; the add may use the carry chain.

## Structure
- The shared package holds:
  - the state enum (IDLE, MUL, OUT);
  - a function returning D from LOGQ and W;
  - the counter width, clog2(D).
- Sub-module mul_digit_mac: computes acc_out = acc_in + ((A · digit) << shift·W). It is combinational with a parameterized shift and is instantiated once. The top level holds the FSM, the counter and the registers.

## Test plan
All cases use the default parameters.
- Reset then idle:
  - after rst deasserts: in_ready = 1, out_valid = 0, C = 0.
  - with in_valid held low for 20 cycles: no out_valid.
- Single product: A = 3, B = 5, qH_in = 0x1234 -> in cycle 5 after accept, out_valid = 1 for exactly one cycle, C = 15, qH_out = 0x1234.
- Maximum operands: A = B = 2^60−1 -> C = 2^120 − 2^61 + 1, with no overflow. Also B = 2^59 alone, which exercises the partial top digit.
- Back-to-back: present new operands in every OUT cycle for 8 consecutive products -> an out_valid every 5 cycles; each C and qH_out matches its own inputs in order; in_ready is low during MUL.
- Reset mid-MUL: assert rst in cycle 2 after an accept -> no out_valid; outputs are zero immediately, asynchronously. The next accepted pair produces the correct C.
- Random regression: 10,000 random A, B, qH_in with random in_valid gaps, checked against a reference model. Also feed C and qH_out into the downstream reducer and check T against (A·B·2^(−ITER·R)) mod q.

Source files
------------

// File: rtl/int_mul_iter_pkg.sv
// rtl/int_mul_iter_pkg.sv - shared types and sizing helpers for the digit-serial multiplier
package int_mul_iter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Number of W-bit digits needed to cover a LOGQ-bit multiplier.
  function automatic int num_digits(input int logq, input int w);
    return (logq + w - 1) / w;
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int cnt_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/int_mul_iter_mul_digit_mac.sv
// rtl/int_mul_iter_mul_digit_mac.sv - one multiply-accumulate column: acc_out = acc_in + ((a * digit) << shift*W)
//
// Ports:
//   acc_in  [K]    running accumulator
//   a       [LOGQ] multiplicand
//   digit   [W]    current multiplier digit
//   shift   [SW]   digit index; partial product is placed at bit shift*W
//   acc_out [K]    updated accumulator (purely combinational)
module mul_digit_mac
  import int_mul_iter_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int W    = 17,
  parameter int K    = 120,
  parameter int SW   = 2
) (
  input  logic [K-1:0]    acc_in,
  input  logic [LOGQ-1:0] a,
  input  logic [W-1:0]    digit,
  input  logic [SW-1:0]   shift,
  output logic [K-1:0]    acc_out
);

  localparam int PW = LOGQ + W;

  logic [PW-1:0] prod;

  // Single LOGQ x W product; maps onto the DSP column.
  assign prod = PW'(a) * PW'(digit);

  // The product always fits below bit K once shifted, so the K-bit add never loses a carry.
  assign acc_out = acc_in + (K'(prod) << (32'(shift) * W));

endmodule

// File: rtl/int_mul_iter.sv
// rtl/int_mul_iter.sv - iterative digit-serial multiplier C = A*B feeding the Montgomery reducer
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   A, B, qH_in valid
//   in_ready   ready to accept (IDLE or OUT, and not in reset)
//   A [LOGQ]   multiplicand
//   B [LOGQ]   multiplier, consumed one W-bit digit per cycle
//   qH_in      modulus high word travelling with the operands
//   out_valid  one-cycle pulse, C and qH_out valid
//   C [2*LOGQ] product
//   qH_out     qH captured with the operands that produced C
module int_mul_iter
  import int_mul_iter_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int R    = 17,
  parameter int W    = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOGQ-1:0]      A,
  input  logic [LOGQ-1:0]      B,
  input  logic [LOGQ-R-1:0]    qH_in,
  output logic                 out_valid,
  output logic [2*LOGQ-1:0]    C,
  output logic [LOGQ-R-1:0]    qH_out
);

  localparam int K     = 2 * LOGQ;
  localparam int LOGQH = LOGQ - R;
  localparam int D     = num_digits(LOGQ, W);
  localparam int JW    = cnt_width(D);
  localparam int BW    = D * W;

  state_t            state;
  logic [LOGQ-1:0]   a_reg;
  logic [LOGQ-1:0]   b_reg;
  logic [LOGQH-1:0]  qh_reg;
  logic [K-1:0]      acc;
  logic [JW-1:0]     j;

  logic [BW-1:0]     b_pad;
  logic [W-1:0]      digit;
  logic [K-1:0]      mac_out;
  logic              accept;

  // Ready is a pure function of state and reset so the upstream handshake has no loop through in_valid.
  assign in_ready = ((state == ST_IDLE) || (state == ST_OUT)) && rst;
  assign accept   = in_valid && in_ready;

  // Zero-padding B to a whole number of digits makes the top digit a zero-extended partial digit.
  assign b_pad = BW'(b_reg);
  assign digit = W'(b_pad >> (32'(j) * W));

  mul_digit_mac #(
    .LOGQ (LOGQ),
    .W    (W),
    .K    (K),
    .SW   (JW)
  ) u_mac (
    .acc_in  (acc),
    .a       (a_reg),
    .digit   (digit),
    .shift   (j),
    .acc_out (mac_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      qh_reg    <= '0;
      acc       <= '0;
      j         <= '0;
      out_valid <= 1'b0;
      C         <= '0;
      qH_out    <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_OUT: begin
          if (accept) begin
            a_reg  <= A;
            b_reg  <= B;
            qh_reg <= qH_in;
            acc    <= '0;
            j      <= '0;
            state  <= ST_MUL;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc <= mac_out;
          j   <= j + 1'b1;
          if (j == JW'(D - 1)) begin
            // C and qH_out are separate registers so they hold while the accumulator
            // is cleared by a back-to-back accept in the OUT cycle.
            C         <= mac_out;
            qH_out    <= qh_reg;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
